// File: rtl/ext_pkg.sv
// ext_pkg: shared constants for the immediate extender.
// Extension-mode encodings and default widths.
package ext_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int IMM_W = 16;
  localparam int OUT_W = 32;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extension.
// Load-upper, sign-extend or zero-extend of Imm.
module ext_core
  import ext_pkg::EXT_SIGN;
#(
  parameter int IMM_W = ext_pkg::IMM_W,
  parameter int OUT_W = ext_pkg::OUT_W
) (
  input  logic [IMM_W-1:0] Imm,
  input  logic             EXTop,
  input  logic             Lui,
  output logic [OUT_W-1:0] o_ext
);

  localparam int PAD_W = OUT_W - IMM_W;

  logic w_sign;
  assign w_sign = !Lui && (EXTop == EXT_SIGN);

  // select extension; load-upper wins over EXTop
  always_comb begin
    o_ext = '0;
    unique case (1'b1)
      Lui:     o_ext = {Imm, {PAD_W{1'b0}}};
      w_sign:  o_ext = {{PAD_W{Imm[IMM_W-1]}}, Imm};
      default: o_ext = {{PAD_W{1'b0}}, Imm};
    endcase
  end

endmodule

// File: rtl/ext.sv
// ext: registered immediate extender.
// One register stage after ext_core, with a valid flag.
module ext #(
  parameter int IMM_W = ext_pkg::IMM_W,
  parameter int OUT_W = ext_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             EXTop,
  input  logic             Lui,
  input  logic [IMM_W-1:0] Imm,
  output logic [OUT_W-1:0] ExtImm,
  output logic             out_valid
);

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_ext;
  logic             r_vld;

  ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .Imm   (Imm),
    .EXTop (EXTop),
    .Lui   (Lui),
    .o_ext (w_ext)
  );

  // capture extended value on valid input; flag pulses per input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext <= '0;
      r_vld <= 1'b0;
    end else begin
      if (in_valid) r_ext <= w_ext;
      r_vld <= in_valid;
    end
  end

  assign ExtImm    = r_ext;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_ext.sv
// tb_ext: self-checking bench for ext.
// Vector table, corner sequences, random vs model.
module tb_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        EXTop;
  logic        Lui;
  logic [15:0] Imm;
  logic [31:0] ExtImm;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  ext dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .EXTop     (EXTop),
    .Lui       (Lui),
    .Imm       (Imm),
    .ExtImm    (ExtImm),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        e;
    logic        l;
    logic [15:0] imm;
    logic [31:0] x_ext;
    logic        x_vld;
  } vec_t;

  vec_t vec[12];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e,
                       input logic l, input logic [15:0] im);
    @(negedge clk);
    in_valid = v;
    EXTop    = e;
    Lui      = l;
    Imm      = im;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic e,
                                        input logic l,
                                        input logic [15:0] im);
    int s;
    if (l) return 32'(im) * 32'd65536;
    if (e) begin
      s = int'(im);
      if (s >= 32768) s = s - 65536;
      return 32'(s);
    end
    return 32'(im);
  endfunction

  logic [31:0] m_ext;
  logic        m_vld;
  logic        rv, re, rl;
  logic [15:0] ri;

  initial begin
    vec[0]  = '{1, 0, 0, 16'h8001, 32'h0000_8001, 1};
    vec[1]  = '{1, 1, 0, 16'h8001, 32'hFFFF_8001, 1};
    vec[2]  = '{1, 1, 0, 16'h7FFF, 32'h0000_7FFF, 1};
    vec[3]  = '{1, 1, 1, 16'h1234, 32'h1234_0000, 1};
    vec[4]  = '{1, 0, 1, 16'hABCD, 32'hABCD_0000, 1};
    vec[5]  = '{1, 0, 0, 16'h00FF, 32'h0000_00FF, 1};
    vec[6]  = '{0, 1, 1, 16'hAAAA, 32'h0000_00FF, 0};
    vec[7]  = '{0, 0, 0, 16'h5555, 32'h0000_00FF, 0};
    vec[8]  = '{1, 1, 0, 16'hFFFF, 32'hFFFF_FFFF, 1};
    vec[9]  = '{1, 0, 0, 16'hFFFF, 32'h0000_FFFF, 1};
    vec[10] = '{1, 1, 0, 16'h0000, 32'h0000_0000, 1};
    vec[11] = '{1, 1, 0, 16'h8000, 32'hFFFF_8000, 1};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    EXTop    = 1'b1;
    Lui      = 1'b0;
    Imm      = 16'hFFFF;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_ext", ExtImm, 32'h0);
      check("rst_vld", 32'(out_valid), 32'h0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_vld", 32'(out_valid), 32'h0);
    check("post_rst_ext", ExtImm, 32'h0);

    for (int i = 0; i < 12; i++) begin
      drive(vec[i].v, vec[i].e, vec[i].l, vec[i].imm);
      check($sformatf("vec%0d_ext", i), ExtImm, vec[i].x_ext);
      check($sformatf("vec%0d_vld", i), 32'(out_valid),
            32'(vec[i].x_vld));
    end

    drive(1, 1, 0, 16'h0001);
    check("b2b0_ext", ExtImm, 32'h0000_0001);
    check("b2b0_vld", 32'(out_valid), 32'h1);
    drive(1, 1, 0, 16'hFFFF);
    check("b2b1_ext", ExtImm, 32'hFFFF_FFFF);
    check("b2b1_vld", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ext", ExtImm, 32'h0);
    check("async_vld", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rel_idle_vld", 32'(out_valid), 32'h0);
    check("rel_idle_ext", ExtImm, 32'h0);

    @(negedge clk);
    rst_n = 1'b0;
    #2;
    in_valid = 1'b1;
    EXTop    = 1'b0;
    Lui      = 1'b0;
    Imm      = 16'h4321;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_valid_ext", ExtImm, 32'h0000_4321);
    check("rel_valid_vld", 32'(out_valid), 32'h1);

    m_ext = ExtImm === 32'h0000_4321 ? 32'h0000_4321 : 32'h0000_4321;
    m_vld = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 3) != 0);
      re = 1'($urandom);
      rl = 1'($urandom_range(0, 3) == 0);
      ri = 16'($urandom);
      if (rv) m_ext = model(re, rl, ri);
      m_vld = rv;
      drive(rv, re, rl, ri);
      check("rand_ext", ExtImm, m_ext);
      check("rand_vld", 32'(out_valid), 32'(m_vld));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext.md
Name: ext

Overview:
- Registered immediate extender for the single-cycle/multi-cycle MIPS datapath.
- Takes the 16-bit instruction immediate and produces a 32-bit operand for the ALU/address path.
- Supports zero extension, sign extension and load-upper (Imm << 16).
- Sits between the instruction-field decode and the ALU B-operand mux.

Parameters:
- IMM_W, 16, immediate input width.
- OUT_W, 32, extended output width; must be ≥ 2*IMM_W for the load-upper mode.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  Imm/EXTop/Lui sampled this cycle
- EXTop  input  1  0 = zero-extend, 1 = sign-extend
- Lui  input  1  1 = load-upper mode (overrides EXTop)
- Imm  input  IMM_W  raw immediate field
- ExtImm  output  OUT_W  extended immediate, registered
- out_valid  output  1  ExtImm updated on the previous edge

Behaviour:
- Reset (rst_n low, asynchronous, at any time) forces ExtImm = 0 and out_valid = 0 immediately.
  - Both outputs hold those values until the first rising edge after rst_n deasserts.
- Latency is exactly one clock: inputs sampled at rising edge N appear on ExtImm after edge N.
- When in_valid = 1 at an edge, the output is loaded in priority order:
  - Lui = 1: ExtImm = {Imm, (OUT_W-IMM_W) zeros}, i.e. Imm in the upper bits, lower bits zero; EXTop is ignored.
  - Lui = 0, EXTop = 0: ExtImm = {(OUT_W-IMM_W) zeros, Imm}.
  - Lui = 0, EXTop = 1: ExtImm = {(OUT_W-IMM_W) copies of Imm[IMM_W-1], Imm}.
  - out_valid is set to 1.
- When in_valid = 0 at an edge: ExtImm holds its previous value and out_valid is set to 0.
- No back-pressure: every valid input produces exactly one valid output cycle. Back-to-back valid inputs give back-to-back results.
- X on EXTop/Lui/Imm while in_valid = 0 must not affect the outputs.
- Reset asserted mid-stream discards the in-flight result; out_valid = 0 on the cycle after release unless in_valid is high at that edge.
- Extension logic is purely combinational ahead of a single register stage; no other state.

Decomposition:
- Shared package ext_pkg holds:
  - localparam encodings EXT_ZERO = 1'b0 and EXT_SIGN = 1'b1;
  - defaults IMM_W = 16 and OUT_W = 32.
- One natural combinational sub-module, ext_core:
  - inputs: Imm, EXTop, Lui;
  - output: unregistered extended value.
- The top module ext wraps ext_core with the output/valid register.

Test Plan:
- Reset: hold rst_n = 0 with Imm = 16'hFFFF, EXTop = 1, in_valid = 1 → ExtImm = 32'h0000_0000 and out_valid = 0, held through clock edges.
- Zero-extend: Imm = 16'h8001, EXTop = 0, Lui = 0, in_valid = 1 → next cycle ExtImm = 32'h0000_8001, out_valid = 1.
- Sign-extend negative/positive:
  - Imm = 16'h8001, EXTop = 1 → 32'hFFFF_8001.
  - Imm = 16'h7FFF, EXTop = 1 → 32'h0000_7FFF.
- Load-upper: Imm = 16'h1234, Lui = 1, EXTop = 1 → 32'h1234_0000.
- Hold/valid: valid Imm = 16'h00FF (zero-extend), then in_valid = 0 with Imm = 16'hAAAA → ExtImm stays 32'h0000_00FF, out_valid drops to 0.
- Async reset mid-stream: back-to-back valid inputs 16'h0001 then 16'hFFFF (sign-extend), then pulse rst_n low between edges → ExtImm = 0 and out_valid = 0 immediately, without waiting for a clock edge.
